// File: rtl/pong_pkg.sv
// Shared definitions for the pong engine: FSM and winner encodings,
// default playfield geometry and a decimal-to-BCD constant helper.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GAME_OVER = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_t;

  localparam int DEF_X_MIN            = 10;
  localparam int DEF_X_MAX            = 640;
  localparam int DEF_Y_MIN            = 5;
  localparam int DEF_Y_MAX            = 470;
  localparam int DEF_BALL_SIZE        = 5;
  localparam int DEF_PAD_W            = 10;
  localparam int DEF_PAD_H            = 100;
  localparam int DEF_PAD1_X           = 15;
  localparam int DEF_PAD2_X           = 630;
  localparam int DEF_PAD_DY           = 3;
  localparam int DEF_MAX_SPEED        = 4;
  localparam int DEF_HITS_PER_SPEEDUP = 4;
  localparam int DEF_WIN_SCORE        = 11;
  localparam int DEF_SERVE_TICKS      = 100;
  localparam int DEF_SCORE_DIGITS     = 2;

  // Signed 11-bit positions so off-screen intermediate values never wrap.
  localparam int POS_W = 11;
  typedef logic signed [POS_W-1:0] pos_t;

  // Up to four BCD digits of a decimal constant, ones digit in the LSBs.
  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD score counter with synchronous clear and increment,
// saturating at all nines; also exposes the would-be incremented value.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] count_inc
);

  logic [4*DIGITS-1:0] count_q;
  logic                all_nines;
  logic                carry;

  always_comb begin
    all_nines = 1'b1;
    carry     = 1'b1;
    count_inc = count_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (count_q[d*4 +: 4] != 4'd9) all_nines = 1'b0;
    end
    if (!all_nines) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (carry) begin
          if (count_q[d*4 +: 4] == 4'd9) begin
            count_inc[d*4 +: 4] = 4'd0;
          end else begin
            count_inc[d*4 +: 4] = count_q[d*4 +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count_q <= '0;
    else if (clear) count_q <= '0;
    else if (inc)   count_q <= count_inc;
  end

  assign count = count_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game core: serve/play/game-over FSM, paddle and ball motion on the
// frame tick, wall and paddle reflection, BCD scoring and speed-up.
module pong_engine
  import pong_pkg::*;
#(
  parameter int X_MIN            = DEF_X_MIN,
  parameter int X_MAX            = DEF_X_MAX,
  parameter int Y_MIN            = DEF_Y_MIN,
  parameter int Y_MAX            = DEF_Y_MAX,
  parameter int BALL_SIZE        = DEF_BALL_SIZE,
  parameter int PAD_W            = DEF_PAD_W,
  parameter int PAD_H            = DEF_PAD_H,
  parameter int PAD1_X           = DEF_PAD1_X,
  parameter int PAD2_X           = DEF_PAD2_X,
  parameter int PAD_DY           = DEF_PAD_DY,
  parameter int MAX_SPEED        = DEF_MAX_SPEED,
  parameter int HITS_PER_SPEEDUP = DEF_HITS_PER_SPEEDUP,
  parameter int WIN_SCORE        = DEF_WIN_SCORE,
  parameter int SERVE_TICKS      = DEF_SERVE_TICKS,
  parameter int SCORE_DIGITS     = DEF_SCORE_DIGITS
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic                      pause,
  input  logic                      start,
  input  logic                      btn_1_up,
  input  logic                      btn_1_down,
  input  logic                      btn_2_up,
  input  logic                      btn_2_down,
  output logic [9:0]                ball_x,
  output logic [9:0]                ball_y,
  output logic [9:0]                paddle_1_y,
  output logic [9:0]                paddle_2_y,
  output logic [4*SCORE_DIGITS-1:0] score_1,
  output logic [4*SCORE_DIGITS-1:0] score_2,
  output logic [2:0]                speed,
  output logic [2:0]                state,
  output logic [1:0]                winner,
  output logic                      point_pulse
);

  localparam int SW    = 4*SCORE_DIGITS;
  localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam int HIT_W = (HITS_PER_SPEEDUP < 2) ? 1 : $clog2(HITS_PER_SPEEDUP + 1);

  localparam pos_t X_MIN_S   = pos_t'(X_MIN);
  localparam pos_t X_MAX_S   = pos_t'(X_MAX);
  localparam pos_t Y_MIN_S   = pos_t'(Y_MIN);
  localparam pos_t Y_MAX_S   = pos_t'(Y_MAX);
  localparam pos_t BALL_S    = pos_t'(BALL_SIZE);
  localparam pos_t PAD_H_S   = pos_t'(PAD_H);
  localparam pos_t PAD_DY_S  = pos_t'(PAD_DY);
  localparam pos_t PAD1_X_S  = pos_t'(PAD1_X);
  localparam pos_t PAD2_X_S  = pos_t'(PAD2_X);
  localparam pos_t P1_FACE   = pos_t'(PAD1_X + PAD_W);
  localparam pos_t P2_FACE   = pos_t'(PAD2_X - BALL_SIZE);
  localparam pos_t P2_BACK   = pos_t'(PAD2_X + PAD_W);
  localparam pos_t CX        = pos_t'((X_MIN + X_MAX) / 2);
  localparam pos_t CY        = pos_t'((Y_MIN + Y_MAX) / 2);
  localparam pos_t PAD_Y_MAX = pos_t'(Y_MAX - PAD_H);
  localparam pos_t PAD_Y0    = pos_t'((Y_MIN + Y_MAX - PAD_H) / 2);
  localparam logic [SW-1:0] WIN_BCD = SW'(to_bcd(WIN_SCORE));

  function automatic pos_t paddle_step(input pos_t y, input logic up, input logic dn);
    pos_t t;
    t = y;
    if (up && !dn)      t = y - PAD_DY_S;
    else if (dn && !up) t = y + PAD_DY_S;
    if (t < Y_MIN_S)        t = Y_MIN_S;
    else if (t > PAD_Y_MAX) t = PAD_Y_MAX;
    return t;
  endfunction

  function automatic logic [2:0] speed_up(input logic [2:0] s);
    return (s >= 3'(MAX_SPEED)) ? s : s + 3'd1;
  endfunction

  state_t           state_q, state_d;
  winner_t          winner_q;
  pos_t             bx_q, by_q, p1_q, p2_q;
  pos_t             p1_d, p2_d, spd;
  pos_t             nx_raw, ny_raw, nx, ny;
  logic             dx_right_q, dy_down_q, serve_dy_q, ndy;
  logic [2:0]       speed_q;
  logic [HIT_W-1:0] hits_q, hits_inc;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             go, adv, play_adv, hit1, hit2, miss1, miss2, point, win;
  logic             inc1, inc2;
  logic [SW-1:0]    s1_next, s2_next;

  // start wins over tick; pause masks both
  assign go       = start && !pause;
  assign adv      = tick && !pause && !start;
  assign play_adv = adv && (state_q == ST_PLAY);

  assign p1_d     = paddle_step(p1_q, btn_1_up, btn_1_down);
  assign p2_d     = paddle_step(p2_q, btn_2_up, btn_2_down);
  assign spd      = $signed({{(POS_W-3){1'b0}}, speed_q});
  assign hits_inc = hits_q + HIT_W'(1);

  // Ball step: walls first, then paddle faces checked against the moved paddles
  always_comb begin
    nx_raw = dx_right_q ? bx_q + spd : bx_q - spd;
    ny_raw = dy_down_q ? by_q + spd : by_q - spd;
    ny     = ny_raw;
    ndy    = dy_down_q;
    if (!dy_down_q && (by_q - spd <= Y_MIN_S)) begin
      ny  = Y_MIN_S;
      ndy = 1'b1;
    end else if (dy_down_q && (by_q + BALL_S + spd >= Y_MAX_S)) begin
      ny  = Y_MAX_S - BALL_S;
      ndy = 1'b0;
    end
    hit1 = !dx_right_q && (nx_raw <= P1_FACE) && (bx_q >= PAD1_X_S) &&
           (ny + BALL_S > p1_d) && (ny < p1_d + PAD_H_S);
    hit2 = dx_right_q && (nx_raw + BALL_S >= PAD2_X_S) && (bx_q + BALL_S <= P2_BACK) &&
           (ny + BALL_S > p2_d) && (ny < p2_d + PAD_H_S);
    nx = nx_raw;
    if (hit1)      nx = P1_FACE;
    else if (hit2) nx = P2_FACE;
    miss2 = !hit1 && (nx_raw <= X_MIN_S);
    miss1 = !hit2 && (nx_raw + BALL_S >= X_MAX_S);
  end

  assign point = play_adv && (miss1 || miss2);
  assign inc1  = play_adv && miss1;
  assign inc2  = play_adv && miss2;
  assign win   = (miss1 && (s1_next == WIN_BCD)) || (miss2 && (s2_next == WIN_BCD));

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score_1 (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .clear     (go),
    .inc       (inc1),
    .count     (score_1),
    .count_inc (s1_next)
  );

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score_2 (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .clear     (go),
    .inc       (inc2),
    .count     (score_2),
    .count_inc (s2_next)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (go) begin
      state_d = ST_SERVE;
    end else if (adv) begin
      case (state_q)
        ST_SERVE: if (cnt_q <= CNT_W'(1)) state_d = ST_PLAY;
        ST_PLAY:  if (point) state_d = win ? ST_GAME_OVER : ST_SERVE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state  = state_q;
    winner = winner_q;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      winner_q   <= WIN_NONE;
      bx_q       <= CX;
      by_q       <= CY;
      p1_q       <= PAD_Y0;
      p2_q       <= PAD_Y0;
      dx_right_q <= 1'b1;
      dy_down_q  <= 1'b1;
      serve_dy_q <= 1'b1;
      speed_q    <= 3'd1;
      hits_q     <= '0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      pulse_q <= point;
      if (go) begin
        winner_q   <= WIN_NONE;
        bx_q       <= CX;
        by_q       <= CY;
        dx_right_q <= 1'b1;
        dy_down_q  <= 1'b1;
        serve_dy_q <= 1'b1;
        speed_q    <= 3'd1;
        hits_q     <= '0;
        cnt_q      <= CNT_W'(SERVE_TICKS);
      end else if (adv) begin
        case (state_q)
          ST_SERVE: begin
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            cnt_q <= (cnt_q > CNT_W'(1)) ? cnt_q - CNT_W'(1) : '0;
          end
          ST_PLAY: begin
            p1_q <= p1_d;
            p2_q <= p2_d;
            if (point && win) begin
              winner_q <= miss1 ? WIN_P1 : WIN_P2;
            end else if (point) begin
              // Serve toward the loser; vertical direction alternates per serve
              bx_q       <= CX;
              by_q       <= CY;
              dx_right_q <= miss1;
              dy_down_q  <= !serve_dy_q;
              serve_dy_q <= !serve_dy_q;
              speed_q    <= 3'd1;
              hits_q     <= '0;
              cnt_q      <= CNT_W'(SERVE_TICKS);
            end else begin
              bx_q       <= nx;
              by_q       <= ny;
              dy_down_q  <= ndy;
              dx_right_q <= hit1 ? 1'b1 : (hit2 ? 1'b0 : dx_right_q);
              if (hit1 || hit2) begin
                if (hits_inc == HIT_W'(HITS_PER_SPEEDUP)) begin
                  hits_q  <= '0;
                  speed_q <= speed_up(speed_q);
                end else begin
                  hits_q <= hits_inc;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ball_x      = bx_q[9:0];
  assign ball_y      = by_q[9:0];
  assign paddle_1_y  = p1_q[9:0];
  assign paddle_2_y  = p2_q[9:0];
  assign speed       = speed_q;
  assign point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_engine.sv
// Randomised bench for pong_engine against a behavioural game model kept
// in plain integers (decimal scores, signed unit directions).
module tb_pong_engine;

  logic       CLOCK_50, reset_n;
  logic       tick, pause, start;
  logic       btn_1_up, btn_1_down, btn_2_up, btn_2_down;
  logic [9:0] ball_x, ball_y, paddle_1_y, paddle_2_y;
  logic [7:0] score_1, score_2;
  logic [2:0] speed, state;
  logic [1:0] winner;
  logic       point_pulse;

  pong_engine dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .tick        (tick),
    .pause       (pause),
    .start       (start),
    .btn_1_up    (btn_1_up),
    .btn_1_down  (btn_1_down),
    .btn_2_up    (btn_2_up),
    .btn_2_down  (btn_2_down),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .paddle_1_y  (paddle_1_y),
    .paddle_2_y  (paddle_2_y),
    .score_1     (score_1),
    .score_2     (score_2),
    .speed       (speed),
    .state       (state),
    .winner      (winner),
    .point_pulse (point_pulse)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;
  int n_points = 0;
  bit seen_over = 0;
  bit seen_fast = 0;

  // Game model: states 0 idle, 1 serve, 2 play, 3 over
  int ms, mbx, mby, mdx, mdy, mserve_dy, mp1, mp2;
  int msc1, msc2, mspd, mhits, mcnt, mwin, mpulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int bcd(input int v);
    return ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic bit overlaps(input int y, input int pad);
    return (y < pad + 100) && (pad < y + 5);
  endfunction

  task automatic model_reset();
    ms = 0; mbx = 325; mby = 237; mdx = 1; mdy = 1; mserve_dy = 1;
    mp1 = 187; mp2 = 187; msc1 = 0; msc2 = 0; mspd = 1; mhits = 0;
    mcnt = 0; mwin = 0; mpulse = 0;
  endtask

  task automatic new_serve();
    mbx = 325; mby = 237; mspd = 1; mhits = 0; mcnt = 100; ms = 1;
  endtask

  task automatic play_tick();
    int nx, ny, scorer;
    bit hit;
    nx = mbx + mspd * mdx;
    ny = mby + mspd * mdy;
    hit = 0;
    scorer = 0;
    if (mdy < 0 && mby - mspd <= 5) begin ny = 5; mdy = 1; end
    else if (mdy > 0 && mby + 5 + mspd >= 470) begin ny = 465; mdy = -1; end
    if (mdx < 0 && nx <= 25 && mbx >= 15 && overlaps(ny, mp1)) begin
      hit = 1; nx = 25; mdx = 1;
    end else if (mdx > 0 && nx + 5 >= 630 && mbx + 5 <= 640 && overlaps(ny, mp2)) begin
      hit = 1; nx = 625; mdx = -1;
    end else if (nx <= 10) scorer = 2;
    else if (nx + 5 >= 640) scorer = 1;
    if (hit) begin
      mhits++;
      if (mhits == 4) begin
        mhits = 0;
        if (mspd < 4) mspd++;
      end
    end
    if (scorer != 0) begin
      mpulse = 1;
      if (scorer == 1) msc1 = (msc1 < 99) ? msc1 + 1 : 99;
      else             msc2 = (msc2 < 99) ? msc2 + 1 : 99;
      if ((scorer == 1 ? msc1 : msc2) == 11) begin
        ms = 3; mwin = scorer;
      end else begin
        new_serve();
        mdx = (scorer == 1) ? 1 : -1;
        mserve_dy = -mserve_dy;
        mdy = mserve_dy;
      end
    end else begin
      mbx = nx; mby = ny;
    end
  endtask

  task automatic model_step(input bit t, input bit p, input bit s,
                            input bit u1, input bit d1, input bit u2, input bit d2);
    mpulse = 0;
    if (s && !p) begin
      msc1 = 0; msc2 = 0; mwin = 0;
      new_serve();
      mdx = 1; mdy = 1; mserve_dy = 1;
    end else if (t && !p && !s && (ms == 1 || ms == 2)) begin
      mp1 = clampi(mp1 + 3 * (int'(d1) - int'(u1)), 5, 370);
      mp2 = clampi(mp2 + 3 * (int'(d2) - int'(u2)), 5, 370);
      if (ms == 1) begin
        if (mcnt <= 1) begin mcnt = 0; ms = 2; end
        else mcnt--;
      end else begin
        play_tick();
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".ball_x"},  32'(ball_x),      mbx);
    check({ph, ".ball_y"},  32'(ball_y),      mby);
    check({ph, ".pad1"},    32'(paddle_1_y),  mp1);
    check({ph, ".pad2"},    32'(paddle_2_y),  mp2);
    check({ph, ".score1"},  32'(score_1),     bcd(msc1));
    check({ph, ".score2"},  32'(score_2),     bcd(msc2));
    check({ph, ".speed"},   32'(speed),       mspd);
    check({ph, ".state"},   32'(state),       ms);
    check({ph, ".winner"},  32'(winner),      mwin);
    check({ph, ".pulse"},   32'(point_pulse), mpulse);
  endtask

  // Drive one cycle's inputs at the falling edge, sample at the next one
  task automatic cycle(input string ph, input bit t, input bit p, input bit s,
                       input bit u1, input bit d1, input bit u2, input bit d2);
    tick = t; pause = p; start = s;
    btn_1_up = u1; btn_1_down = d1; btn_2_up = u2; btn_2_down = d2;
    model_step(t, p, s, u1, d1, u2, d2);
    @(negedge CLOCK_50);
    compare_all(ph);
    if (state == 3'd3) seen_over = 1;
    if (speed >= 3'd2) seen_fast = 1;
    if (point_pulse) n_points++;
  endtask

  task automatic pick_buttons(input int acc, input int pad, output bit up, output bit dn);
    int target;
    if (int'($urandom_range(99)) < acc) begin
      target = mby + 2 - 50;
      up = (pad > target + 1);
      dn = (pad < target - 1);
    end else begin
      up = 1'($urandom_range(1));
      dn = 1'($urandom_range(1));
    end
  endtask

  task automatic run_random(input string ph, input int ncyc, input int acc1, input int acc2);
    int pause_left;
    bit t, p, s, u1, d1, u2, d2;
    pause_left = 0;
    for (int i = 0; i < ncyc && n_fail < 10; i++) begin
      if (pause_left > 0) pause_left--;
      else if ($urandom_range(299) == 0) pause_left = int'($urandom_range(20, 1));
      p = (pause_left > 0);
      t = ($urandom_range(7) != 0);
      s = ((ms == 0 || ms == 3) && $urandom_range(39) == 0) || ($urandom_range(7999) == 0);
      pick_buttons(acc1, mp1, u1, d1);
      pick_buttons(acc2, mp2, u2, d2);
      cycle(ph, t, p, s, u1, d1, u2, d2);
    end
  endtask

  int snap_bx, snap_by, snap_p1, snap_p2, snap_st;

  initial begin
    reset_n = 1'b0;
    tick = 0; pause = 0; start = 0;
    btn_1_up = 0; btn_1_down = 0; btn_2_up = 0; btn_2_down = 0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    compare_all("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) cycle("idle", 1, 0, 0, 1, 0, 0, 1);

    cycle("start", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cycle("serve", 1, 0, 0, 0, 0, 0, 0);
      if (i == 98) check("serve_tick99_state", 32'(state), 1);
    end
    check("serve_done_state", 32'(state), 2);
    check("serve_done_x", 32'(ball_x), 325);
    check("serve_done_y", 32'(ball_y), 237);
    check("serve_done_speed", 32'(speed), 1);

    run_random("rallyA", 15000, 95, 95);

    snap_bx = mbx; snap_by = mby; snap_p1 = mp1; snap_p2 = mp2; snap_st = ms;
    for (int i = 0; i < 50; i++) cycle("pause", 1, 1, (i == 25), 1, 1, 1, 1);
    check("pause_hold_x", 32'(ball_x), snap_bx);
    check("pause_hold_y", 32'(ball_y), snap_by);
    check("pause_hold_p1", 32'(paddle_1_y), snap_p1);
    check("pause_hold_p2", 32'(paddle_2_y), snap_p2);
    check("pause_hold_state", 32'(state), snap_st);

    cycle("restart", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 130; i++) cycle("p1top", 1, 0, 0, 1, 0, 0, 0);
    check("p1_top_clamp", 32'(paddle_1_y), 5);

    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all("async_rst");
    @(negedge CLOCK_50);
    compare_all("rst_hold");
    reset_n = 1'b1;

    run_random("rallyB", 30000, 95, 0);

    check("cov_game_over", 32'(seen_over), 1);
    check("cov_speedup", 32'(seen_fast), 1);
    check("cov_points", 32'(n_points > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- X_MIN 10 left playfield limit (pixels); X_MAX 640 right limit; Y_MIN 5 top limit; Y_MAX 470 bottom limit.
- BALL_SIZE 5 ball edge; PAD_W 10, PAD_H 100 paddle size; PAD1_X 15, PAD2_X 630 paddle left edges.
- PAD_DY 3 paddle step per tick; MAX_SPEED 4 max ball step per tick; HITS_PER_SPEEDUP 4 paddle hits per speed increment.
- WIN_SCORE 11 points to win (decimal); SERVE_TICKS 100 ticks of serve delay; SCORE_DIGITS 2 BCD digits per score.
REQ-002 Ports, one per line: name direction width meaning:
- CLOCK_50 in 1 sole clock, rising edge.
- reset_n in 1 asynchronous, active-low reset.
- tick in 1 one-cycle frame strobe; all motion advances only on tick.
- pause in 1 level; freezes all game state.
- start in 1 one-cycle strobe; begins or restarts a game.
- btn_1_up, btn_1_down, btn_2_up, btn_2_down in 1 each, debounced, active-high.
- ball_x, ball_y out 10 each: ball top-left corner.
- paddle_1_y, paddle_2_y out 10 each: paddle top edge.
- score_1, score_2 out 4*SCORE_DIGITS each: BCD score, ones digit in LSBs.
- speed out 3: current ball step (1..MAX_SPEED).
- state out 3: current FSM state code.
- winner out 2: 0 none, 1 player 1, 2 player 2.
- point_pulse out 1: one-cycle pulse when a point is awarded.

Function
REQ-003 FSM states: IDLE, SERVE, PLAY, GAME_OVER; codes 0..3 on state.
REQ-004 IDLE: on start -> SERVE, scores cleared, serve counter loaded with SERVE_TICKS.
REQ-005 SERVE: ball held at centre ((X_MIN+X_MAX)/2, (Y_MIN+Y_MAX)/2); counter decrements on each unpaused tick; reaching 0 -> PLAY; paddles movable.
REQ-006 PLAY: on each unpaused tick, paddles move, then ball advances by speed in x and y, using directions dx, dy.
REQ-007 Paddle: up subtracts PAD_DY, down adds PAD_DY; both or neither pressed -> no move; clamp to [Y_MIN, Y_MAX-PAD_H].
REQ-008 Walls: if ball_y-speed <= Y_MIN, dy becomes down and ball_y is set to Y_MIN; if ball_y+BALL_SIZE+speed >= Y_MAX, dy becomes up and ball_y is set to Y_MAX-BALL_SIZE.
REQ-009 Paddle 1 hit: dx left, next x <= PAD1_X+PAD_W, current x >= PAD1_X, vertical overlap -> dx right, ball_x = PAD1_X+PAD_W, hit count +1; paddle 2 is mirrored, with ball_x = PAD2_X-BALL_SIZE.
REQ-010 Wall and paddle reflections in the same tick both apply.
REQ-011 Miss: next x <= X_MIN -> point to player 2; next x+BALL_SIZE >= X_MAX -> point to player 1; point_pulse fires the following cycle.
REQ-012 Speed: starts at 1 per serve; every HITS_PER_SPEEDUP hits +1, saturating at MAX_SPEED; hit count clears at serve.
REQ-013 Score: BCD increment with digit carry, saturating at all-9s. When the score equals WIN_SCORE -> GAME_OVER, winner set; otherwise -> SERVE with counter reloaded.
REQ-014 Serve direction: dx toward the player who lost the point; dy alternates each serve, first serve down-right.
REQ-015 GAME_OVER: ball frozen, paddles frozen; start -> scores cleared, winner 0, SERVE.
REQ-016 pause=1: no state, counter, position or score changes; start is ignored while paused.
REQ-017 start and tick in the same cycle: start transition wins, no motion that cycle.
REQ-018 All internal position arithmetic is 11-bit signed to avoid wrap-around; outputs are truncated to 10 bits after clamping.

Reset
REQ-019 reset_n low asynchronously forces state IDLE, scores 0, winner 0, speed 1, point_pulse 0, ball at centre, both paddles at (Y_MIN+Y_MAX-PAD_H)/2, dx right, dy down, hit and serve counters 0.
REQ-020 Reset asserted mid-game aborts immediately; release resumes in IDLE.

Structure
REQ-021 Package pong_pkg holds the state encoding, winner codes and default geometry constants.
REQ-022 One sub-module, bcd_counter (SCORE_DIGITS-parameterised, inc/clear, saturating), instantiated once per player.

Verification
REQ-023 Reset, start, 100 ticks -> state SERVE to PLAY on tick 100, ball at (325,237), speed 1.
REQ-024 Ball moving up at y=6, speed 1, one tick -> ball_y=5, dy down.
REQ-025 Paddle 1 at y=200, ball reaching x=25 at y=250 -> dx right; after 4 hits -> speed 2.
REQ-026 Paddle 1 at y=5, ball crossing X_MIN -> point_pulse, score_2=0x01, SERVE, dx left.
REQ-027 score_1=0x10 when a point is scored for player 1 -> score_1=0x11, GAME_OVER, winner 1; start -> scores 0x00, SERVE.
REQ-028 pause=1 for 50 ticks with both buttons pressed -> all outputs unchanged; btn_1_up held at y=5 -> paddle_1_y stays 5.
